// File: rtl/sd_link_arbiter.sv
// Shares one user_io SD link between N sd_card requesters, one sector transfer per grant.
// Define SD_LINK_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round robin.
module sd_link_arbiter #(
    parameter int unsigned N    = 2,
    parameter int unsigned IDXW = 1,
    parameter int unsigned GAP  = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [32*N-1:0]   req_lba,
    input  logic [N-1:0]      req_rd,
    input  logic [N-1:0]      req_wr,
    output logic [N-1:0]      req_ack,
    output logic [N-1:0]      req_ack_conf,
    input  logic [N-1:0]      req_conf,
    input  logic [8*N-1:0]    req_buff_din,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    input  logic              sd_ack_conf,
    output logic              sd_conf,
    output logic [7:0]        sd_buff_din,
    output logic [IDXW-1:0]   grant_idx,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StReq, StXfer, StRelease} state_e;

    state_e          state_q, state_d;
    logic [IDXW-1:0] grant_q, grant_d;
    logic [31:0]     lba_q, lba_d;
    logic            rd_q, rd_d, wr_q, wr_d;
    logic [3:0]      gap_q, gap_d;

    logic [N-1:0]    req_any;
    logic            found;
    logic [IDXW-1:0] winner;
    logic [31:0]     win_lba;
    logic            win_rd, win_wr;
    logic            grant_req;
    logic [N-1:0]    ack_vec;
    logic [7:0]      buff_sel;

    assign req_any = req_rd | req_wr;

`ifdef SD_LINK_ARB_FIXED_PRIO_EN
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_any[i]) begin
                found  = 1'b1;
                winner = IDXW'(i);
            end
        end
    end
`else
    logic [IDXW-1:0] rr_q, rr_d;
    logic [2*N-1:0]  req_rot;

    // Rotate so bit 0 is the requester at the search start pointer.
    assign req_rot = {req_any, req_any} >> rr_q;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                found  = 1'b1;
                winner = IDXW'((int'(rr_q) + k) % N);
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (state_q == StIdle && found) begin
            rr_d = IDXW'((int'(winner) + 1) % N);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_comb begin
        win_lba   = '0;
        win_rd    = 1'b0;
        win_wr    = 1'b0;
        grant_req = 1'b0;
        ack_vec   = '0;
        buff_sel  = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == IDXW'(i)) begin
                win_lba = req_lba[32*i +: 32];
                win_rd  = req_rd[i];
                win_wr  = req_wr[i];
            end
            if (grant_q == IDXW'(i)) begin
                grant_req  = req_any[i];
                ack_vec[i] = sd_ack;
                buff_sel   = req_buff_din[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        gap_d   = gap_q;
        req_ack = '0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = winner;
                    lba_d   = win_lba;
                    rd_d    = win_rd;
                    wr_d    = win_wr & ~win_rd;
                    state_d = StReq;
                end
            end
            StReq: begin
                // Ack is forwarded from its first cycle so the requester sees the whole pulse.
                req_ack = ack_vec;
                if (sd_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                req_ack = ack_vec;
                if (!sd_ack) begin
                    gap_d   = 4'(GAP);
                    state_d = StRelease;
                end
            end
            StRelease: begin
                // Wait for the owner to drop its request so a stale level is never re-granted.
                if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end else if (!grant_req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            lba_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            gap_q   <= gap_d;
        end
    end

    assign sd_lba       = lba_q;
    assign sd_rd        = rd_q;
    assign sd_wr        = wr_q;
    assign grant_idx    = grant_q;
    assign busy         = (state_q != StIdle);
    assign sd_conf      = |req_conf;
    assign req_ack_conf = {N{sd_ack_conf}};
    assign sd_buff_din  = buff_sel;

endmodule
